// File: rtl/bitnet_pkg.sv
// rtl/bitnet_pkg.sv - shared widths, int8 limits and rounding/saturation helper
//
// Contents:
//   IN_WIDTH/ACC_WIDTH/SCALE_WIDTH/OUT_WIDTH : default datapath widths
//   Q_MIN/Q_MAX                              : int8 saturation limits
//   SAT_W                                    : working width of sat_round
//   sat_round()                              : round-half-up, arithmetic shift, clamp
package bitnet_pkg;

  localparam int IN_WIDTH    = 20;
  localparam int ACC_WIDTH   = 32;
  localparam int SCALE_WIDTH = 16;
  localparam int OUT_WIDTH   = 8;

  localparam int Q_MIN = -128;
  localparam int Q_MAX = 127;

  // Callers sign-extend their product into SAT_W bits. Products up to
  // SAT_W-1 bits wide leave headroom so the rounding bias cannot wrap.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_round(
    input logic signed [SAT_W-1:0] x,
    input logic        [4:0]       sh,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    logic signed [SAT_W-1:0] bias;
    logic signed [SAT_W-1:0] r;
    bias = (sh == 5'd0) ? '0 : (SAT_W'(1) << (sh - 5'd1));
    r = (x + bias) >>> sh;
    if (r < lo) begin
      r = lo;
    end else if (r > hi) begin
      r = hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   s_tvalid   : push request; accepted when not full or when popping this cycle
//   s_tdata    : push data
//   m_tready   : pop request; ignored when empty
//   m_tdata    : head entry (zero after reset)
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = m_tready && !empty;
  assign do_push = s_tvalid && (!full || do_pop);
  assign m_tdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= s_tdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bitnet_requant_stage.sv
// rtl/bitnet_requant_stage.sv - chunk accumulator and int8 requantizer with output FIFO
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : tree sum valid (never stalled)
//   in_sum      : signed tree sum
//   scale/shift : requant multiplier and right shift, latched on chunk 0
//   out_valid   : FIFO head valid
//   out_ready   : consumer pops the head
//   out_data    : signed saturated result at the FIFO head
//   overflow    : sticky, set when a finished result found the FIFO full
module bitnet_requant_stage #(
  parameter int IN_WIDTH    = bitnet_pkg::IN_WIDTH,
  parameter int ACC_WIDTH   = bitnet_pkg::ACC_WIDTH,
  parameter int CHUNKS      = 4,
  parameter int SCALE_WIDTH = bitnet_pkg::SCALE_WIDTH,
  parameter int OUT_WIDTH   = bitnet_pkg::OUT_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [IN_WIDTH-1:0]    in_sum,
  input  logic signed [SCALE_WIDTH-1:0] scale,
  input  logic        [4:0]             shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          overflow
);

  import bitnet_pkg::*;

  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PROD_W = ACC_WIDTH + SCALE_WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);
  localparam logic signed [SAT_W-1:0] OUT_MAX = (SAT_W'(1) <<< (OUT_WIDTH - 1)) - SAT_W'(1);
  localparam logic signed [SAT_W-1:0] OUT_MIN = -(SAT_W'(1) <<< (OUT_WIDTH - 1));

  logic [CNT_W-1:0]              cnt;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic signed [ACC_WIDTH-1:0]   in_ext;
  logic signed [SCALE_WIDTH-1:0] scale_l;
  logic signed [SCALE_WIDTH-1:0] scale_sel;
  logic        [4:0]             shift_l;
  logic        [4:0]             shift_sel;
  logic                          first;
  logic                          last;

  logic                          s1_valid;
  logic signed [ACC_WIDTH-1:0]   s1_acc;
  logic signed [SCALE_WIDTH-1:0] s1_scale;
  logic        [4:0]             s1_shift;

  logic                          s2_valid;
  logic signed [PROD_W-1:0]      s2_prod;
  logic        [4:0]             s2_shift;

  logic signed [SAT_W-1:0]       r_full;
  logic signed [OUT_WIDTH-1:0]   r_q;
  logic                          fifo_full;
  logic                          fifo_empty;

  assign in_ext = ACC_WIDTH'(in_sum);
  assign first  = (cnt == '0);
  assign last   = (cnt == LAST);

  // Chunk 0 restarts the sum, so a group never depends on the previous acc.
  // With CHUNKS=1 first and last coincide and the live scale/shift are used.
  assign acc_next  = first ? in_ext : (acc + in_ext);
  assign scale_sel = first ? scale  : scale_l;
  assign shift_sel = first ? shift  : shift_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      scale_l  <= '0;
      shift_l  <= '0;
      s1_valid <= 1'b0;
      s1_acc   <= '0;
      s1_scale <= '0;
      s1_shift <= '0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_shift <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        acc <= acc_next;
        cnt <= last ? '0 : (cnt + CNT_W'(1));
        if (first) begin
          scale_l <= scale;
          shift_l <= shift;
        end
      end

      s1_valid <= in_valid && last;
      if (in_valid && last) begin
        s1_acc   <= acc_next;
        s1_scale <= scale_sel;
        s1_shift <= shift_sel;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod  <= PROD_W'(s1_acc) * PROD_W'(s1_scale);
        s2_shift <= s1_shift;
      end

      // A same-cycle pop frees the slot, so only a push into a full,
      // non-draining FIFO loses data.
      if (s2_valid && fifo_full && !(out_valid && out_ready)) begin
        overflow <= 1'b1;
      end
    end
  end

  assign r_full = sat_round(SAT_W'(s2_prod), s2_shift, OUT_MIN, OUT_MAX);
  assign r_q    = OUT_WIDTH'(r_full);

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s2_valid),
    .s_tdata  (r_q),
    .m_tready (out_ready),
    .m_tdata  (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_bitnet_requant_stage.sv
// tb/tb_bitnet_requant_stage.sv - self-checking bench for bitnet_requant_stage
module tb_bitnet_requant_stage;

  localparam int CHUNKS = 4;
  localparam int DEPTH  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [19:0] in_sum;
  logic signed [15:0] scale;
  logic        [4:0]  shift;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               overflow;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  bitnet_requant_stage #(
    .IN_WIDTH    (20),
    .ACC_WIDTH   (32),
    .CHUNKS      (CHUNKS),
    .SCALE_WIDTH (16),
    .OUT_WIDTH   (8),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .scale     (scale),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int     wc;
    longint v;
  } pend_t;

  longint mq[$];
  pend_t  pq[$];
  int     cyc  = 0;
  int     mcnt = 0;
  longint dot  = 0;
  longint lsc  = 0;
  int     lsh  = 0;
  bit     mov  = 1'b0;

  function automatic longint requant(input longint d, input longint sc, input int sh);
    longint p;
    p = d * sc;
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return p;
  endfunction

  always @(posedge clk) begin : model
    bit pop;
    cyc++;
    if (rst) begin
      mq.delete();
      pq.delete();
      mcnt = 0;
      dot  = 0;
      mov  = 1'b0;
    end else begin
      pop = (mq.size() > 0) && out_ready;
      if (pq.size() > 0 && pq[0].wc == cyc) begin
        if (mq.size() == DEPTH && !pop) mov = 1'b1;
        else mq.push_back(pq[0].v);
        void'(pq.pop_front());
      end
      if (pop) void'(mq.pop_front());
      if (in_valid) begin
        if (mcnt == 0) begin
          dot = 0;
          lsc = scale;
          lsh = shift;
        end
        dot = dot + in_sum;
        mcnt++;
        if (mcnt == CHUNKS) begin
          pq.push_back('{cyc + 2, requant(dot, lsc, lsh)});
          mcnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("cmp_valid", out_valid, (mq.size() > 0));
      if (mq.size() > 0) check("cmp_data", out_data, mq[0]);
      check("cmp_overflow", overflow, mov);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chunk(input int s);
    in_valid = 1'b1;
    in_sum   = 20'(s);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic group(input int a, input int b, input int c, input int d, input int sc, input int sh);
    scale = 16'(sc);
    shift = 5'(sh);
    chunk(a);
    chunk(b);
    chunk(c);
    chunk(d);
  endtask

  task automatic expect_result(input string name, input int exp);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (out_valid) got = 1'b1;
    end
    check({name, "_seen"}, got, 1);
    if (got) check(name, out_data, exp);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    scale     = '0;
    shift     = '0;
    out_ready = 1'b1;
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // basic path with latency
    group(100, 200, -50, 30, 3, 3);
    lat = 0;
    while (lat < 10 && !out_valid) begin
      @(negedge clk);
      lat++;
    end
    check("basic_latency", lat, 3);
    check("basic_data", out_data, 105);
    idle(2);

    // rounding and saturation
    group(2, 1, 1, 1, 1, 1);
    expect_result("round_pos", 3);
    group(-2, -1, -1, -1, 1, 1);
    expect_result("round_neg", -2);
    group(100, 100, 50, 30, 1, 0);
    expect_result("sat_pos", 127);
    group(-250, -250, -250, -250, 1, 0);
    expect_result("sat_neg", -128);
    group(500000, 500000, 500000, 500000, -32768, 31);
    expect_result("wide_prod", -31);

    // gaps and latching
    scale = 16'sd2;
    shift = 5'd0;
    chunk(1);
    scale = 16'sd7;
    idle(2);
    chunk(1);
    idle(1);
    chunk(1);
    idle(3);
    chunk(1);
    expect_result("gap_latch", 8);
    idle(2);

    // reset mid-group, with in_valid asserted during reset
    scale = 16'sd1;
    shift = 5'd0;
    chunk(50);
    chunk(50);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sum   = 20'sd50;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    group(1, 1, 1, 1, 1, 0);
    expect_result("rst_mid", 4);
    idle(6);
    check("rst_mid_single", out_valid, 0);
    check("rst_mid_ovf", overflow, 0);

    // backpressure and drop
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) group(k, 0, 0, 0, 1, 0);
    idle(5);
    check("bp_overflow", overflow, 1);
    check("bp_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("bp_drain", out_data, k);
    end
    @(negedge clk);
    check("bp_empty", out_valid, 0);
    check("bp_ovf_sticky", overflow, 1);
    @(posedge clk);
    #1;

    // clear overflow, then full FIFO with a pop in the push cycle
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("ovf_cleared", overflow, 0);
    out_ready = 1'b0;
    for (int k = 6; k <= 9; k++) group(k, 0, 0, 0, 1, 0);
    group(10, 0, 0, 0, 1, 0);
    idle(1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("full_pop_ovf", overflow, 0);
    idle(2);
    out_ready = 1'b1;
    for (int k = 7; k <= 10; k++) begin
      @(negedge clk);
      check("full_pop_drain", out_data, k);
    end
    @(negedge clk);
    check("full_pop_empty", out_valid, 0);
    check("full_pop_ovf_end", overflow, 0);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
